// File: rtl/dma_axi_pkg.sv
// Shared types and AXI constants for the DMA copy engine.
package dma_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5
  } dma_state_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [3:0] WSTRB_ALL      = 4'hF;

  localparam int NUM_W = 14;  // transfer length field width
  localparam int LEN_W = 9;   // burst length 1..256

  // Words remaining before the next 4KB page, given the word offset in the page.
  function automatic logic [10:0] words_to_4k(input logic [9:0] word_in_page);
    return 11'd1024 - {1'b0, word_in_page};
  endfunction

endpackage

// File: rtl/dma_len_calc.sv
// Burst length = min(remaining, MAX_BURST, words to src 4KB page end, words to dst 4KB page end).
module dma_len_calc
  import dma_axi_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [NUM_W-1:0] remaining_i,
  input  logic [9:0]       src_word_i,
  input  logic [9:0]       dst_word_i,
  output logic [LEN_W-1:0] len_o
);

  logic [NUM_W-1:0] src_left;
  logic [NUM_W-1:0] dst_left;
  logic [NUM_W-1:0] len_min;

  // NOTE: combinational blocks use blocking '=' so each step sees the value just computed.
  always_comb begin
    src_left = NUM_W'(words_to_4k(src_word_i));
    dst_left = NUM_W'(words_to_4k(dst_word_i));
    len_min  = remaining_i;
    if (NUM_W'(MAX_BURST) < len_min) len_min = NUM_W'(MAX_BURST);
    if (src_left < len_min)          len_min = src_left;
    if (dst_left < len_min)          len_min = dst_left;
    len_o = LEN_W'(len_min);
  end

endmodule

// File: rtl/dma_axi_engine.sv
// AXI4 copy engine: read burst into a local buffer, then write it out, until the count is exhausted.
// Define DMA_ERR_ABORT_EN to stop after the burst that saw an error response.
module dma_axi_engine
  import dma_axi_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              dma_axi_start,
  input  logic [31:0]       dma_cfg_saddr,
  input  logic [31:0]       dma_cfg_daddr,
  input  logic [NUM_W-1:0]  dma_cfg_number,
  output logic              dma_axi_done,
  output logic              dma_err,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  input  logic [31:0]       axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic [1:0]        axi_awburst,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  output logic [31:0]       axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wlast,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  input  logic [1:0]        axi_bresp
);

  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [NUM_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  calc_len;
  logic              last_beat;
  logic              buf_we;
  logic [31:0]       buf_q [2**BEAT_W];
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{dma_cfg_saddr[1:0], dma_cfg_daddr[1:0]};
  assign last_beat        = (beat_q == len_q - 1'b1);

  dma_len_calc #(.MAX_BURST(MAX_BURST)) u_len_calc (
    .remaining_i (remaining_d),
    .src_word_i  (saddr_d[11:2]),
    .dst_word_i  (daddr_d[11:2]),
    .len_o       (calc_len)
  );

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    saddr_d     = saddr_q;
    daddr_d     = daddr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    err_d       = err_q;
    buf_we      = 1'b0;
    case (state_q)
      ST_IDLE: if (dma_axi_start && dma_cfg_number != '0) begin
        saddr_d     = ADDR_W'({dma_cfg_saddr[31:2], 2'b00});
        daddr_d     = ADDR_W'({dma_cfg_daddr[31:2], 2'b00});
        remaining_d = dma_cfg_number;
        beat_d      = '0;
        err_d       = 1'b0;
        state_d     = ST_RD_ADDR;
      end
      ST_RD_ADDR: if (axi_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (axi_rvalid) begin
        buf_we = 1'b1;
        if (axi_rresp != RESP_OKAY || axi_rlast != last_beat) err_d = 1'b1;
        // The beat count ends the burst; a misplaced rlast is only flagged.
        if (last_beat) begin
          beat_d  = '0;
          state_d = ST_WR_ADDR;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_WR_ADDR: if (axi_awready) state_d = ST_WR_DATA;
      ST_WR_DATA: if (axi_wready) begin
        if (last_beat) begin
          beat_d  = '0;
          state_d = ST_WR_RESP;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_WR_RESP: if (axi_bvalid) begin
        if (axi_bresp != RESP_OKAY) err_d = 1'b1;
        saddr_d     = saddr_q + ADDR_W'({len_q, 2'b00});
        daddr_d     = daddr_q + ADDR_W'({len_q, 2'b00});
        remaining_d = remaining_q - NUM_W'(len_q);
        state_d     = (remaining_d == '0) ? ST_IDLE : ST_RD_ADDR;
`ifdef DMA_ERR_ABORT_EN
        if (err_d) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Length is frozen on entry to RD_ADDR and reused for the matching write burst.
  always_comb begin
    len_d = len_q;
    if (state_d == ST_RD_ADDR && state_q != ST_RD_ADDR) len_d = calc_len;
  end

  // NOTE: sequential state is updated with non-blocking '<=' to avoid ordering races.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      saddr_q     <= '0;
      daddr_q     <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      saddr_q     <= saddr_d;
      daddr_q     <= daddr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the data buffer is not reset; every entry is written before it is read.
  always_ff @(posedge hclk) begin
    if (buf_we) buf_q[beat_q[BEAT_W-1:0]] <= axi_rdata;
  end

  assign dma_axi_done = (state_q == ST_IDLE);
  assign dma_err      = err_q;

  assign axi_arvalid = (state_q == ST_RD_ADDR);
  assign axi_araddr  = saddr_q;
  assign axi_arlen   = 8'(len_q - 1'b1);
  assign axi_arsize  = AXI_SIZE_WORD;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_rready  = (state_q == ST_RD_DATA);

  assign axi_awvalid = (state_q == ST_WR_ADDR);
  assign axi_awaddr  = daddr_q;
  assign axi_awlen   = 8'(len_q - 1'b1);
  assign axi_awsize  = AXI_SIZE_WORD;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wvalid  = (state_q == ST_WR_DATA);
  assign axi_wdata   = buf_q[beat_q[BEAT_W-1:0]];
  assign axi_wstrb   = WSTRB_ALL;
  assign axi_wlast   = (state_q == ST_WR_DATA) && last_beat;
  assign axi_bready  = (state_q == ST_WR_RESP);

endmodule

// File: tb/tb_dma_axi_engine.sv
// Randomised bench: AXI slave memory model plus a burst-plan reference computed from the copy rules.
module tb_dma_axi_engine;
  import dma_axi_pkg::*;

  localparam int MAXB = 16;

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    int          len;
  } burst_t;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] saddr = '0, daddr = '0;
  logic [13:0] number = '0;
  logic        done, err;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready, rlast = 1'b0;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast, bvalid = 1'b0, bready;
  logic [31:0] araddr, awaddr, rdata = '0, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp = '0, bresp = '0;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  dma_axi_engine #(.MAX_BURST(MAXB), .ADDR_W(32)) dut (
    .hclk(clk), .hreset(hreset), .dma_axi_start(start),
    .dma_cfg_saddr(saddr), .dma_cfg_daddr(daddr), .dma_cfg_number(number),
    .dma_axi_done(done), .dma_err(err),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arlen(arlen),
    .axi_arsize(arsize), .axi_arburst(arburst),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awlen(awlen),
    .axi_awsize(awsize), .axi_awburst(awburst),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp)
  );

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference plan and slave-side bookkeeping
  burst_t      exp_ar[$], exp_aw[$], rd_q[$], plan_q[$];
  logic [31:0] dst [logic [31:0]];
  burst_t      wr_b;
  int          rd_beat, wr_beat, r_idx, b_idx, rerr_idx, berr_idx, lbad_idx;
  int          exp_bursts, total_wbeats, valid_seen, stall;
  bit          wr_active, b_pending, done_chk;

  task automatic plan(input logic [31:0] s_in, input logic [31:0] d_in, input int n);
    logic [31:0] s, d;
    int rem, l, ls, ld;
    burst_t b;
    s = s_in & ~32'h3;
    d = d_in & ~32'h3;
    rem = n;
    exp_ar.delete(); exp_aw.delete(); plan_q.delete();
    while (rem > 0) begin
      ls = (4096 - int'(s % 4096)) / 4;
      ld = (4096 - int'(d % 4096)) / 4;
      l = rem;
      if (MAXB < l) l = MAXB;
      if (ls < l) l = ls;
      if (ld < l) l = ld;
      b.s = s; b.d = d; b.len = l;
      exp_ar.push_back(b); exp_aw.push_back(b); plan_q.push_back(b);
      s += 32'(4 * l); d += 32'(4 * l); rem -= l;
    end
  endtask

  task automatic reset_slave();
    rd_q.delete(); dst.delete();
    rd_beat = 0; wr_beat = 0; r_idx = 0; b_idx = 0; total_wbeats = 0;
    wr_active = 0; b_pending = 0; done_chk = 0;
    arready = 0; rvalid = 0; rlast = 0; rresp = '0; awready = 0; wready = 0; bvalid = 0; bresp = '0;
  endtask

  function automatic bit go();
    return ($urandom_range(99) >= stall);
  endfunction

  // Called at each falling edge: DUT outputs are stable, handshakes fire at the next rising edge.
  task automatic slave_step();
    burst_t b;
    bit     last;
    if (done_chk) begin
      check("done_rise", done, 1);
      done_chk = 0;
    end
    if (arvalid || awvalid || wvalid) valid_seen++;
    // Read data
    rvalid = 0; rlast = 0; rresp = RESP_OKAY;
    if (rd_q.size() > 0 && go()) begin
      b = rd_q[0];
      last = (rd_beat == b.len - 1);
      rvalid = 1;
      rdata = src_word(b.s + 32'(4 * rd_beat));
      rlast = (r_idx == lbad_idx) ? !last : last;
      rresp = (r_idx == rerr_idx && last) ? 2'b10 : RESP_OKAY;
      if (rready) begin
        rd_beat++;
        if (rd_beat == b.len) begin
          rd_beat = 0;
          void'(rd_q.pop_front());
          r_idx++;
        end
      end
    end
    // Read address
    arready = go();
    if (arvalid && arready) begin
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else begin
        b = exp_ar.pop_front();
        check("araddr", araddr, b.s);
        check("arlen", arlen, b.len - 1);
        rd_q.push_back(b);
      end
    end
    // Write response
    bvalid = 0; bresp = RESP_OKAY;
    if (b_pending && go()) begin
      bvalid = 1;
      bresp = (b_idx == berr_idx) ? 2'b10 : RESP_OKAY;
      if (bready) begin
        b_pending = 0;
        b_idx++;
        if (b_idx == exp_bursts) done_chk = 1;
      end
    end
    // Write data
    wready = go();
    if (wvalid) begin
      if (!wr_active) check("w_before_aw", 1, 0);
      else if (wready) begin
        dst[wr_b.d + 32'(4 * wr_beat)] = wdata;
        check("wlast", wlast, wr_beat == wr_b.len - 1);
        wr_beat++;
        total_wbeats++;
        if (wr_beat == wr_b.len) begin
          wr_active = 0;
          b_pending = 1;
        end
      end
    end
    // Write address
    awready = go();
    if (awvalid && awready) begin
      if (wr_active || exp_aw.size() == 0) check("aw_unexpected", 1, 0);
      else begin
        wr_b = exp_aw.pop_front();
        check("awaddr", awaddr, wr_b.d);
        check("awlen", awlen, wr_b.len - 1);
        wr_active = 1;
        wr_beat = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  // Launch a copy and track it to completion; reset_at > 0 pulls hreset after that many W beats.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int rerr, input int berr, input int lbad, input int reset_at);
    int nb, first_err, words, cyc;
    plan(s, d, n);
    reset_slave();
    nb = exp_ar.size();
    rerr_idx = rerr; berr_idx = berr; lbad_idx = lbad;
    first_err = -1;
    if (rerr >= 0 && rerr < nb) first_err = rerr;
    if (berr >= 0 && berr < nb && (first_err < 0 || berr < first_err)) first_err = berr;
    if (lbad >= 0 && lbad < nb && (first_err < 0 || lbad < first_err)) first_err = lbad;
`ifdef DMA_ERR_ABORT_EN
    exp_bursts = (first_err >= 0) ? first_err + 1 : nb;
`else
    exp_bursts = nb;
`endif
    if (reset_at > 0) exp_bursts = -1;
    start = 1; saddr = s; daddr = d; number = 14'(n);
    tick();
    check("done_fall", done, 0);
    check("err_cleared", err, 0);
    start = 0; saddr = $urandom; daddr = $urandom; number = 14'($urandom);
    tick();
    start = 1;
    tick();
    start = 0;
    cyc = 0;
    while (!done && cyc < 20000) begin
      if (reset_at > 0 && total_wbeats >= reset_at) break;
      tick();
      cyc++;
    end
    if (cyc >= 20000) begin
      check("timeout_done", 0, 1);
      return;
    end
    if (reset_at > 0) begin
      hreset = 1;
      tick();
      check("rst_done", done, 1);
      check("rst_err", err, 0);
      check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
      reset_slave();
      exp_ar.delete(); exp_aw.delete();
      hreset = 0;
      tick();
      check("rst_idle", done, 1);
      return;
    end
    check("dma_err", err, first_err >= 0);
    check("ar_left", exp_ar.size(), nb - exp_bursts);
    check("aw_left", exp_aw.size(), nb - exp_bursts);
    words = 0;
    for (int i = 0; i < exp_bursts; i++) words += plan_q[i].len;
    check("wr_count", dst.num(), words);
    for (int i = 0; i < words; i++) begin
      logic [31:0] a;
      a = (d & ~32'h3) + 32'(4 * i);
      check("dst_word", dst.exists(a) ? dst[a] : 32'hDEAD_BEEF, src_word((s & ~32'h3) + 32'(4 * i)));
    end
    repeat (3) tick();
    check("idle_after", done, 1);
  endtask

  initial begin
    int v0, lowc;
    stall = 0;
    rerr_idx = -1; berr_idx = -1; lbad_idx = -1; exp_bursts = -1; valid_seen = 0;
    reset_slave();
    repeat (3) tick();
    check("reset_done", done, 1);
    check("reset_err", err, 0);
    check("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("arsize", arsize, 3'b010);
    check("awburst", awburst, 2'b01);
    check("wstrb", wstrb, 4'hF);
    hreset = 0;
    tick();

    run_xfer(32'h1000, 32'h2000, 4, -1, -1, -1, 0);
    run_xfer(32'h1000, 32'h2000, 40, -1, -1, -1, 0);
    run_xfer(32'h0FF8, 32'h3000, 4, -1, -1, -1, 0);

    v0 = valid_seen; lowc = 0;
    start = 1; number = '0; saddr = 32'h1000; daddr = 32'h2000;
    repeat (12) begin
      tick();
      if (!done) lowc++;
    end
    start = 0;
    check("zero_valids", valid_seen - v0, 0);
    check("zero_done_low", lowc, 0);

    stall = 30;
    run_xfer(32'h1000, 32'h5000, 48, -1, 0, -1, 0);
    run_xfer(32'h2000, 32'h6000, 40, 1, -1, -1, 0);
    run_xfer(32'h3000, 32'h7000, 20, -1, -1, 0, 0);
    run_xfer(32'h4000, 32'h8000, 8, -1, -1, -1, 0);

    for (int k = 0; k < 8; k++) begin
      stall = $urandom_range(60);
      run_xfer($urandom & 32'h000F_FFFF, $urandom & 32'h000F_FFFF, $urandom_range(1, 70), -1, -1, -1, 0);
    end

    stall = 25;
    run_xfer(32'h1000, 32'h9000, 40, -1, -1, -1, 20);
    run_xfer(32'h1F00, 32'hA0F0, 70, -1, -1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
